// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU; owns PC, IR and the Z/C flags.
// Optional feature: define CPU_CTRL_TRAP_EN to trap unused opcodes into HALT with illegal set.
module cpu_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [3:0] alu_sel,
  input  logic       alu_z,
  input  logic       alu_c,
  output logic       accum_we,
  output logic       acc_src,
  output logic [7:0] imm,
  output logic [3:0] reg_addr,
  output logic       reg_we,
  output logic       flag_z,
  output logic       flag_c,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_OPER,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_MOVR = 4'b0100;
  localparam logic [3:0] OP_MOVA = 4'b0101;
  localparam logic [3:0] OP_JZ   = 4'b0110;
  localparam logic [3:0] OP_JC   = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_LDI  = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  state_e     state_q;
  logic [7:0] pc_q;
  logic [7:0] ir_q;
  logic [7:0] imm_q;
  logic       flag_z_q;
  logic       flag_c_q;
  logic       mem_req_q;
  logic [3:0] alu_sel_q;
  logic       accum_we_q;
  logic       acc_src_q;
  logic       reg_we_q;
  logic       halted_q;
  logic [3:0] op;
  logic [7:0] pc_inc_d;

  assign op       = ir_q[7:4];
  assign pc_inc_d = pc_q + 8'd1;

`ifdef CPU_CTRL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // NOTE: every register here is sequential state, so it is written with <= only;
  // a blocking assignment would let later lines in this block see half-updated values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 8'h00;
      imm_q      <= 8'h00;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      alu_sel_q  <= OP_NOP;
      accum_we_q <= 1'b0;
      acc_src_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      halted_q   <= 1'b0;
`ifdef CPU_CTRL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      // Write strobes are single-cycle pulses unless a branch below re-arms them.
      accum_we_q <= 1'b0;
      reg_we_q   <= 1'b0;
      case (state_q)
        S_FETCH: begin
          // mem_req is low for the first cycle after reset, so an early ack is ignored.
          if (mem_req_q && mem_ack) begin
            ir_q      <= mem_rdata;
            pc_q      <= pc_inc_d;
            mem_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        S_DECODE: begin
          case (op)
            OP_ADD, OP_SUB, OP_NOR, OP_MOVR, OP_SHL, OP_SHR: begin
              alu_sel_q  <= op;
              accum_we_q <= 1'b1;
              acc_src_q  <= 1'b0;
              state_q    <= S_EXEC;
            end
            OP_MOVA: begin
              reg_we_q <= 1'b1;
              state_q  <= S_EXEC;
            end
            OP_JZ, OP_JC, OP_JMP, OP_LDI: begin
              mem_req_q <= 1'b1;
              state_q   <= S_OPER;
            end
            OP_HLT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            OP_NOP: state_q <= S_EXEC;
`ifdef CPU_CTRL_TRAP_EN
            default: begin
              illegal_q <= 1'b1;
              halted_q  <= 1'b1;
              state_q   <= S_HALT;
            end
`else
            default: state_q <= S_EXEC;
`endif
          endcase
        end
        S_EXEC: begin
          // A non-zero alu_sel marks an ALU op; MOVR leaves carry alone.
          if (alu_sel_q != OP_NOP) begin
            flag_z_q <= alu_z;
            if (alu_sel_q != OP_MOVR) flag_c_q <= alu_c;
          end
          alu_sel_q <= OP_NOP;
          acc_src_q <= 1'b0;
          mem_req_q <= 1'b1;
          state_q   <= S_FETCH;
        end
        S_OPER: begin
          if (mem_req_q && mem_ack) begin
            pc_q      <= pc_inc_d;
            mem_req_q <= 1'b1;
            state_q   <= S_FETCH;
            case (op)
              OP_JMP: pc_q <= mem_rdata;
              OP_JZ:  if (flag_z_q) pc_q <= mem_rdata;
              OP_JC:  if (flag_c_q) pc_q <= mem_rdata;
              OP_LDI: begin
                imm_q      <= mem_rdata;
                accum_we_q <= 1'b1;
                acc_src_q  <= 1'b1;
                mem_req_q  <= 1'b0;
                state_q    <= S_EXEC;
              end
              default: ;
            endcase
          end
        end
        S_HALT: begin
          mem_req_q <= 1'b0;
          halted_q  <= 1'b1;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = pc_q;
  assign alu_sel  = alu_sel_q;
  assign accum_we = accum_we_q;
  assign acc_src  = acc_src_q;
  assign imm      = imm_q;
  assign reg_addr = ir_q[3:0];
  assign reg_we   = reg_we_q;
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;
  assign halted   = halted_q;

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control sequencer for the accumulator CPU. It fetches instruction bytes over a request/acknowledge memory port, decodes them, and drives the ALU opcode plus the accumulator and register-file write enables. It owns the PC and the latched zero/carry flags used by conditional jumps. It sits between the instruction memory and the ALU/accumulator/register-file datapath.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- mem_req  out  1  instruction/operand fetch request
- mem_addr  out  8  fetch address (= PC)
- mem_ack  in  1  fetch complete; mem_rdata valid this cycle
- mem_rdata  in  8  fetched byte
- alu_sel  out  4  ALU opcode: ADD 0001, SUB 0010, NOR 0011, MOVR 0100, SHL 1011, SHR 1100
- alu_z  in  1  ALU zero output
- alu_c  in  1  ALU carry output (result bit 8)
- accum_we  out  1  accumulator write strobe
- acc_src  out  1  accumulator source: 0 = ALU result, 1 = imm
- imm  out  8  immediate operand for LDI
- reg_addr  out  4  register-file index (IR[3:0])
- reg_we  out  1  register-file write strobe (writes accumulator)
- flag_z, flag_c  out  1  latched flags
- halted  out  1  core stopped
- illegal  out  1  illegal opcode trap (CPU_CTRL_TRAP_EN only; else tied 0)

## Operation
- Instruction byte: IR[7:4] opcode, IR[3:0] register index.
- Opcodes: 0000 NOP; ALU ops as alu_sel above; 0101 MOVA (reg[IR[3:0]] <= accum); 0110 JZ, 0111 JC, 1000 JMP, 1001 LDI (two-byte, second byte = address/immediate); 1111 HLT; 1010, 1101, 1110 unused.
- States: FETCH, DECODE, EXEC, OPER, HALT.
- FETCH: mem_req=1, mem_addr=PC. On mem_ack: IR <= mem_rdata, PC <= PC+1, go DECODE.
- DECODE: one cycle; reg_addr driven from IR. Two-byte ops -> OPER; HLT -> HALT; others -> EXEC.
- EXEC: ALU ops: alu_sel=IR[7:4], accum_we=1, acc_src=0; flag_z<=alu_z, flag_c<=alu_c (MOVR updates flag_z only). MOVA: reg_we=1. NOP: no strobes. -> FETCH.
- OPER: mem_req=1 at PC. On mem_ack: PC <= PC+1, then: JMP PC <= mem_rdata; JZ/JC PC <= mem_rdata if flag_z/flag_c set; LDI imm <= mem_rdata, acc_src=1, accum_we=1 the following cycle (EXEC), flags unchanged. -> FETCH (LDI -> EXEC).
- HALT: absorbing; only rst_n leaves it. halted=1.
- alu_sel = 4'b0000 whenever not in EXEC of an ALU op; accum_we never asserted alongside alu_sel 0000 with acc_src=0.
- PC is 8-bit, wraps 8'hFF -> 8'h00 with no flag.

## Timing
- Reset (rst_n=0 at clk edge): state FETCH, PC=RESET_PC, IR=0, imm=0, flag_z=0, flag_c=0, all strobes 0, mem_req=0 for that cycle, halted=0, illegal=0. Reset wins over any simultaneous ack or strobe; a fetch in flight is abandoned.
- mem_req and mem_addr held stable until mem_ack; zero-wait ack allowed (ack in first req cycle). mem_ack while mem_req=0 is ignored.
- One-byte op with zero-wait memory: 3 cycles (FETCH, DECODE, EXEC). JMP/JZ/JC: 3 cycles + operand wait. LDI: 4 cycles + waits.
- Strobes (accum_we, reg_we) are single-cycle pulses.
- JZ/JC test flags as latched before the jump's DECODE; flags from the immediately preceding ALU op are visible.

## Configuration
- CPU_CTRL_TRAP_EN defined: unused opcodes set illegal=1 and enter HALT from DECODE; illegal stays set until reset.
- Undefined: unused opcodes execute as NOP; illegal tied 0.

## Test plan
- Reset: rst_n low 2 cycles, RESET_PC=8'h10 -> mem_req=1, mem_addr=8'h10 first cycle after release; all strobes 0, flags 0.
- LDI 8'h05 then ADD r1 (alu_z=0, alu_c=1 driven) -> accum_we with acc_src=1 and imm=8'h05, then accum_we with alu_sel=0001; flag_c=1, flag_z=0.
- SUB with alu_z=1, then JZ 8'h40 -> next mem_addr=8'h40; repeat with alu_z=0 -> fall through to PC+2.
- mem_ack delayed 3 cycles -> mem_req/mem_addr stable throughout; no strobe before ack; PC at 8'hFF fetch wraps to 8'h00.
- HLT (8'hF0) -> halted=1, mem_req stays 0 indefinitely; rst_n low restarts at RESET_PC.
- Opcode 8'hA0: with CPU_CTRL_TRAP_EN illegal=1 and halted=1; without it, no strobes, next fetch at PC+1.
